// File: rtl/seg_pkg.sv
// Shared 7-segment glyph definitions (segments a..g on bits 0..6).
package seg_pkg;

  localparam int unsigned SEG_W = 7;

  typedef logic [SEG_W-1:0] glyph_t;

  localparam glyph_t GLYPH_0   = 7'h3F;
  localparam glyph_t GLYPH_1   = 7'h06;
  localparam glyph_t GLYPH_2   = 7'h5B;
  localparam glyph_t GLYPH_3   = 7'h4F;
  localparam glyph_t GLYPH_4   = 7'h66;
  localparam glyph_t GLYPH_5   = 7'h6D;
  localparam glyph_t GLYPH_6   = 7'h7D;
  localparam glyph_t GLYPH_7   = 7'h07;
  localparam glyph_t GLYPH_8   = 7'h7F;
  localparam glyph_t GLYPH_9   = 7'h6F;
  localparam glyph_t GLYPH_A   = 7'h77;
  localparam glyph_t GLYPH_B   = 7'h7C;
  localparam glyph_t GLYPH_C   = 7'h39;
  localparam glyph_t GLYPH_D   = 7'h5E;
  localparam glyph_t GLYPH_E   = 7'h79;
  localparam glyph_t GLYPH_F   = 7'h71;
  localparam glyph_t SEG_BLANK = 7'h00;

  // Hex nibble to active-high segment pattern.
  function automatic glyph_t glyph(input logic [3:0] nibble);
    case (nibble)
      4'h0:    glyph = GLYPH_0;
      4'h1:    glyph = GLYPH_1;
      4'h2:    glyph = GLYPH_2;
      4'h3:    glyph = GLYPH_3;
      4'h4:    glyph = GLYPH_4;
      4'h5:    glyph = GLYPH_5;
      4'h6:    glyph = GLYPH_6;
      4'h7:    glyph = GLYPH_7;
      4'h8:    glyph = GLYPH_8;
      4'h9:    glyph = GLYPH_9;
      4'hA:    glyph = GLYPH_A;
      4'hB:    glyph = GLYPH_B;
      4'hC:    glyph = GLYPH_C;
      4'hD:    glyph = GLYPH_D;
      4'hE:    glyph = GLYPH_E;
      default: glyph = GLYPH_F;
    endcase
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational hex-nibble to 7-segment glyph decoder.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output glyph_t     segs_c
);

  // Pure table lookup, active-high segments.
  always_comb begin
    segs_c = glyph(nibble);
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with frame-synchronous buffer update.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned CLK_DIV        = 50000,
  parameter int unsigned GUARD          = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          BLANK_LEADING  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  enable,
  output logic [SEG_W-1:0]      segment,
  output logic                  dp,
  output logic [DIGITS-1:0]     anode,
  output logic                  frame_done
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(DIGITS);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_GUARD = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam glyph_t            SEG_INV   = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_INV    = {DIGITS{AN_ACTIVE_LOW}};

  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [BCD_W-1:0]  pend_bcd;
  logic [DIGITS-1:0] pend_dp;
  logic [BCD_W-1:0]  disp_bcd;
  logic [DIGITS-1:0] disp_dp;

  logic              slot_end_c;
  logic              frame_wrap_c;
  logic              show_c;
  logic [3:0]        cur_nib_c;
  logic              cur_dp_c;
  glyph_t            cur_glyph_c;
  logic [DIGITS-1:0] an_sel_c;
  logic [DIGITS-1:0] blank_mask_c;
  logic              seen_nz_c;

  // Slot timing decisions derived from the current scan position.
  always_comb begin
    slot_end_c   = enable && (cnt == CNT_LAST);
    frame_wrap_c = slot_end_c && (idx == IDX_LAST);
    show_c       = enable && (cnt >= CNT_GUARD);
    cur_nib_c    = disp_bcd[{idx, 2'b00} +: 4];
    cur_dp_c     = disp_dp[idx];
    an_sel_c     = {{(DIGITS-1){1'b0}}, 1'b1} << idx;
  end

  // Leading-zero mask: walk from the most-significant digit down; digit 0 never blanks.
  always_comb begin
    seen_nz_c    = 1'b0;
    blank_mask_c = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen_nz_c       = seen_nz_c | (disp_bcd[4*i +: 4] != 4'h0);
      blank_mask_c[i] = BLANK_LEADING && (i != 0) && !seen_nz_c;
    end
  end

  seg_glyph_decode u_decode (
    .nibble (cur_nib_c),
    .segs_c (cur_glyph_c)
  );

  // Prescaler and digit index; both freeze while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (enable) begin
      if (slot_end_c) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Pending/display double buffer; a load on the wrap edge bypasses straight to display.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_bcd <= '0;
      pend_dp  <= '0;
      disp_bcd <= '0;
      disp_dp  <= '0;
    end else begin
      if (load) begin
        pend_bcd <= bcd_in;
        pend_dp  <= dp_in;
      end
      if (frame_wrap_c) begin
        disp_bcd <= load ? bcd_in : pend_bcd;
        disp_dp  <= load ? dp_in  : pend_dp;
      end
    end
  end

  // Registered pin drivers; polarity is applied only here.
  always_ff @(posedge clk) begin
    if (rst) begin
      segment    <= SEG_INV;
      dp         <= SEG_ACTIVE_LOW;
      anode      <= AN_INV;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_wrap_c;
      if (show_c) begin
        segment <= (blank_mask_c[idx] ? SEG_BLANK : cur_glyph_c) ^ SEG_INV;
        dp      <= cur_dp_c ^ SEG_ACTIVE_LOW;
        anode   <= an_sel_c ^ AN_INV;
      end else begin
        segment <= SEG_INV;
        dp      <= SEG_ACTIVE_LOW;
        anode   <= AN_INV;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with a frame-level behavioural model.
`timescale 1ns/1ps
module tb_seg_scan_driver;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned GUARD   = 1;
  localparam int unsigned FRAME   = DIGITS * CLK_DIV;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        load   = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in  = '0;
  logic [6:0]  segment;
  logic        dp;
  logic [3:0]  anode;
  logic        frame_done;

  seg_scan_driver #(
    .DIGITS         (DIGITS),
    .CLK_DIV        (CLK_DIV),
    .GUARD          (GUARD),
    .SEG_ACTIVE_LOW (1'b0),
    .AN_ACTIVE_LOW  (1'b1),
    .BLANK_LEADING  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .load       (load),
    .enable     (enable),
    .segment    (segment),
    .dp         (dp),
    .anode      (anode),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in frame as a plain tick count, value as an integer.
  int unsigned glyph_tab [16] = '{32'h3F, 32'h06, 32'h5B, 32'h4F, 32'h66, 32'h6D, 32'h7D, 32'h07,
                                  32'h7F, 32'h6F, 32'h77, 32'h7C, 32'h39, 32'h5E, 32'h79, 32'h71};
  int unsigned m_ticks = 0;
  logic [15:0] m_pend  = '0;
  logic [15:0] m_shown = '0;
  logic [3:0]  m_pdp   = '0;
  logic [3:0]  m_sdp   = '0;
  logic [6:0]  e_seg   = '0;
  logic        e_dp    = 1'b0;
  logic [3:0]  e_an    = 4'hF;
  logic        e_fd    = 1'b0;
  bit          model_live = 1'b0;
  bit          watch_one  = 1'b0;
  bit          seen_one   = 1'b0;

  function automatic logic [6:0] model_glyph(input logic [15:0] val, input int unsigned d);
    logic [15:0] upper;
    upper = val >> (4 * d);
    if (d > 0 && upper == 16'h0) return 7'h00;
    return 7'(glyph_tab[upper[3:0]]);
  endfunction

  function automatic logic [15:0] rand_value();
    int unsigned k;
    logic [31:0] m;
    k = $urandom_range(0, 4);
    m = (32'd1 << (4 * k)) - 32'd1;
    return 16'($urandom & m);
  endfunction

  // Model advance on every active edge; expected outputs reflect pre-edge position.
  always @(posedge clk) begin : model
    int unsigned d;
    int unsigned ph;
    bit wrap;
    model_live = 1'b1;
    if (rst) begin
      m_ticks = 0; m_pend = '0; m_shown = '0; m_pdp = '0; m_sdp = '0;
      e_seg = '0; e_dp = 1'b0; e_an = 4'hF; e_fd = 1'b0;
    end else begin
      d  = m_ticks / CLK_DIV;
      ph = m_ticks % CLK_DIV;
      if (!enable || ph < GUARD) begin
        e_seg = '0; e_dp = 1'b0; e_an = 4'hF;
      end else begin
        e_an  = ~(4'b0001 << d);
        e_seg = model_glyph(m_shown, d);
        e_dp  = m_sdp[d];
      end
      wrap = enable && (m_ticks == FRAME - 1);
      e_fd = wrap;
      if (load) begin m_pend = bcd_in; m_pdp = dp_in; end
      if (wrap) begin m_shown = m_pend; m_sdp = m_pdp; end
      if (enable) m_ticks = (m_ticks + 1) % FRAME;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      chk("segment", segment, e_seg);
      chk("dp", dp, e_dp);
      chk("anode", anode, e_an);
      chk("frame_done", frame_done, e_fd);
      chk("anode_onehot", 32'($countones(~anode) <= 1), 1);
      if (watch_one && segment == 7'h06) seen_one = 1'b1;
    end
  end

  task automatic wait_anode(input logic [3:0] tgt, input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (anode !== tgt && n < 64);
    if (anode !== tgt) chk({name, "_timeout"}, anode, tgt);
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (frame_done !== 1'b1 && n < 200);
    if (frame_done !== 1'b1) chk("fd_timeout", frame_done, 1);
  endtask

  task automatic wait_ticks(input int unsigned t);
    int n;
    n = 0;
    while (m_ticks != t && n < 200) begin @(negedge clk); n++; end
    if (m_ticks != t) chk("ticks_timeout", m_ticks, t);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    bcd_in = v; dp_in = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int n;

    // 1: reset, then blank-leading "0" scan
    repeat (3) begin @(negedge clk); chk("reset_anode", anode, 4'hF); end
    chk("reset_segment", segment, 7'h00);
    chk("reset_fd", frame_done, 0);
    rst = 1'b0; enable = 1'b1;
    wait_anode(4'b1110, "t1_d0");
    chk("t1_digit0", segment, 7'h3F);
    chk("t1_dp0", dp, 0);
    wait_anode(4'b1101, "t1_d1");
    chk("t1_blank1", segment, 7'h00);
    wait_fd(n);
    wait_fd(n);
    chk("t1_frame_period", n, 16);

    // 2: 1234 with dp on digit 2, only after frame boundary
    wait_ticks(5);
    do_load(16'h1234, 4'b0100);
    wait_anode(4'b0111, "t2_pre");
    chk("t2_before_commit", segment, 7'h00);
    wait_fd(n);
    wait_anode(4'b1110, "t2_d0"); chk("t2_digit0", segment, 7'h66); chk("t2_dp0", dp, 0);
    wait_anode(4'b1101, "t2_d1"); chk("t2_digit1", segment, 7'h4F);
    wait_anode(4'b1011, "t2_d2"); chk("t2_digit2", segment, 7'h5B); chk("t2_dp2", dp, 1);
    wait_anode(4'b0111, "t2_d3"); chk("t2_digit3", segment, 7'h06);

    // 3: 00A0 leading blanking
    wait_ticks(3);
    do_load(16'h00A0, 4'b0000);
    wait_fd(n);
    wait_anode(4'b1110, "t3_d0"); chk("t3_digit0", segment, 7'h3F);
    wait_anode(4'b1101, "t3_d1"); chk("t3_digit1", segment, 7'h77);
    wait_anode(4'b1011, "t3_d2"); chk("t3_digit2", segment, 7'h00);
    wait_anode(4'b0111, "t3_d3"); chk("t3_digit3", segment, 7'h00);

    // 4: last load wins; load on the wrap edge commits directly
    wait_ticks(2);
    watch_one = 1'b1;
    do_load(16'h1111, 4'b0000);
    wait_ticks(6);
    do_load(16'h2222, 4'b0000);
    wait_ticks(15);
    do_load(16'h3333, 4'b0000);
    chk("t4_coincide_fd", frame_done, 1);
    wait_anode(4'b1110, "t4_d0"); chk("t4_digit0", segment, 7'h4F);
    wait_anode(4'b1101, "t4_d1"); chk("t4_digit1", segment, 7'h4F);
    wait_anode(4'b0111, "t4_d3"); chk("t4_digit3", segment, 7'h4F);
    watch_one = 1'b0;
    chk("t4_1111_hidden", seen_one, 0);

    // 6: enable drop for 10 cycles mid-slot
    wait_fd(n);
    repeat (5) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("t6_dark_anode", anode, 4'hF);
    chk("t6_dark_segment", segment, 7'h00);
    repeat (9) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("t6_resume_digit", anode, 4'b1101);
    wait_fd(n);
    chk("t6_fd_delay", n + 16, 26);

    // 6: reset mid-frame discards pending and shows "0"
    wait_ticks(6);
    do_load(16'h5555, 4'b1111);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_anode", anode, 4'hF);
    rst = 1'b0;
    wait_anode(4'b1110, "t6_r0"); chk("t6_rst_zero", segment, 7'h3F);
    wait_anode(4'b1101, "t6_r1"); chk("t6_rst_blank", segment, 7'h00);
    wait_fd(n);
    wait_anode(4'b1110, "t6_r2"); chk("t6_pending_gone", segment, 7'h3F);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      load = ($urandom_range(0, 7) == 0);
      if (load) begin
        bcd_in = rand_value();
        dp_in  = 4'($urandom);
      end
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      rst = ($urandom_range(0, 799) == 0);
    end
    rst = 1'b0; load = 1'b0; enable = 1'b1;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
